// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants for the partial-product compression pipe:
//                operand count, word width and pipeline depth for both the
//                registered-CPA build (PP_COMPRESS_CPA_STAGE_EN defined) and
//                the combinational-CPA build (macro undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int PP_NUM                  = 8;
    localparam int PP_WIDTH                = 32;

    // Depth with the carry-propagate adder in its own stage / merged into stage 2
    localparam int PIPE_DEPTH_CPA_STAGE    = 3;
    localparam int PIPE_DEPTH_NO_CPA_STAGE = 2;

`ifdef PP_COMPRESS_CPA_STAGE_EN
    localparam int PIPE_DEPTH              = PIPE_DEPTH_CPA_STAGE;
`else
    localparam int PIPE_DEPTH              = PIPE_DEPTH_NO_CPA_STAGE;
`endif

    typedef logic [PP_WIDTH-1:0] pp_word_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/pp_compress_pipe_compressor42.sv
`default_nettype none
// ============================================================================
//  Module      : compressor42
//  Description : 1-bit 4:2 compressor built from two chained full adders.
//                a+b+c+d+cin = sum + 2*(carry + cout). cout does not depend on
//                cin, so a row of these has no ripple path through the chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module compressor42 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);

    logic w_s1;

    assign w_s1  = a ^ b ^ c;
    assign cout  = (a & b) | (a & c) | (b & c);
    assign sum   = w_s1 ^ d ^ cin;
    assign carry = (w_s1 & d) | (w_s1 & cin) | (d & cin);

endmodule : compressor42
`default_nettype wire

// File: rtl/pp_compress_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pp_compress_pipe
//  Description : Reduces eight aligned partial products to one product
//                (mod 2^PP_WIDTH) through 4:2 compressor rows and a CPA, in an
//                elastic valid/ready pipeline with bubble collapsing.
//                Config macro PP_COMPRESS_CPA_STAGE_EN:
//                  defined   -> 3 stages (CPA registered on its own)
//                  undefined -> 2 stages (CPA follows the stage-2 row)
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_compress_pipe #(
    parameter int PP_NUM   = mult_pkg::PP_NUM,
    parameter int PP_WIDTH = mult_pkg::PP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PP_WIDTH-1:0] PP0,
    input  logic [PP_WIDTH-1:0] PP1,
    input  logic [PP_WIDTH-1:0] PP2,
    input  logic [PP_WIDTH-1:0] PP3,
    input  logic [PP_WIDTH-1:0] PP4,
    input  logic [PP_WIDTH-1:0] PP5,
    input  logic [PP_WIDTH-1:0] PP6,
    input  logic [PP_WIDTH-1:0] PP7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PP_WIDTH-1:0] out_product
);

    localparam int C_ROWS = 3;   // rows 0,1: stage-1 halves; row 2: stage 2

    logic [PP_WIDTH-1:0] w_pp        [PP_NUM];
    logic [PP_WIDTH-1:0] w_row_in    [C_ROWS][4];
    logic [PP_WIDTH-1:0] w_row_sum   [C_ROWS];
    logic [PP_WIDTH-1:0] w_row_carry [C_ROWS];
    logic [PP_WIDTH-1:0] w_row_cout  [C_ROWS];
    logic                w_unused_msbs;

    logic                en1, en2;
    logic                v1_q, v1_d, v2_q, v2_d;
    logic [PP_WIDTH-1:0] s1_q [4];
    logic [PP_WIDTH-1:0] s1_d [4];
    logic [PP_WIDTH-1:0] prod_q, prod_d;

    assign w_pp[0] = PP0;
    assign w_pp[1] = PP1;
    assign w_pp[2] = PP2;
    assign w_pp[3] = PP3;
    assign w_pp[4] = PP4;
    assign w_pp[5] = PP5;
    assign w_pp[6] = PP6;
    assign w_pp[7] = PP7;

    // Route compressor-row operands: two halves of the input set, then stage-1 vectors
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_row_in[0][i] = w_pp[i];
            w_row_in[1][i] = w_pp[4+i];
            w_row_in[2][i] = s1_q[i];
        end
    end

    // Each row: one compressor per bit, cout chained upward, LSB cin tied low.
    // The MSB cout and MSB carry have weight 2^PP_WIDTH and are dropped.
    for (genvar r = 0; r < C_ROWS; r++) begin : g_row
        for (genvar b = 0; b < PP_WIDTH; b++) begin : g_bit
            logic w_cin;
            if (b == 0) begin : g_lsb
                assign w_cin = 1'b0;
            end else begin : g_chain
                assign w_cin = w_row_cout[r][b-1];
            end
            compressor42 u_c42 (
                .a     (w_row_in[r][0][b]),
                .b     (w_row_in[r][1][b]),
                .c     (w_row_in[r][2][b]),
                .d     (w_row_in[r][3][b]),
                .cin   (w_cin),
                .sum   (w_row_sum[r][b]),
                .carry (w_row_carry[r][b]),
                .cout  (w_row_cout[r][b])
            );
        end
    end

    assign w_unused_msbs = ^{w_row_cout[0][PP_WIDTH-1], w_row_cout[1][PP_WIDTH-1],
                             w_row_cout[2][PP_WIDTH-1], w_row_carry[0][PP_WIDTH-1],
                             w_row_carry[1][PP_WIDTH-1], w_row_carry[2][PP_WIDTH-1]};

    assign en1         = ~v1_q | en2;
    assign in_ready    = en1;
    assign out_product = prod_q;

    // Stage 1 next state: capture both row outputs (carries shifted into place)
    always_comb begin
        v1_d = v1_q;
        for (int i = 0; i < 4; i++) s1_d[i] = s1_q[i];
        if (en1) begin
            v1_d    = in_valid;
            s1_d[0] = w_row_sum[0];
            s1_d[1] = w_row_carry[0] << 1;
            s1_d[2] = w_row_sum[1];
            s1_d[3] = w_row_carry[1] << 1;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            for (int i = 0; i < 4; i++) s1_q[i] <= '0;
        end else begin
            v1_q <= v1_d;
            for (int i = 0; i < 4; i++) s1_q[i] <= s1_d[i];
        end
    end

`ifdef PP_COMPRESS_CPA_STAGE_EN
    logic                en3;
    logic                v3_q, v3_d;
    logic [PP_WIDTH-1:0] s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;

    assign en3       = ~v3_q | out_ready;
    assign en2       = ~v2_q | en3;
    assign out_valid = v3_q;

    // Stage 2 next state: hold the redundant sum/carry pair
    always_comb begin
        v2_d       = v2_q;
        s2_sum_d   = s2_sum_q;
        s2_carry_d = s2_carry_q;
        if (en2) begin
            v2_d       = v1_q;
            s2_sum_d   = w_row_sum[2];
            s2_carry_d = w_row_carry[2] << 1;
        end
    end

    // Stage 3 next state: carry-propagate add into the product register
    always_comb begin
        v3_d   = v3_q;
        prod_d = prod_q;
        if (en3) begin
            v3_d   = v2_q;
            prod_d = s2_sum_q + s2_carry_q;
        end
    end

    // Stage 2 and 3 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q       <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= '0;
            v3_q       <= 1'b0;
            prod_q     <= '0;
        end else begin
            v2_q       <= v2_d;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
            v3_q       <= v3_d;
            prod_q     <= prod_d;
        end
    end
`else
    logic [PP_WIDTH-1:0] w_cpa_carry;

    assign en2         = ~v2_q | out_ready;
    assign out_valid   = v2_q;
    assign w_cpa_carry = w_row_carry[2] << 1;

    // Stage 2 next state: compress and carry-propagate add in one cycle
    always_comb begin
        v2_d   = v2_q;
        prod_d = prod_q;
        if (en2) begin
            v2_d   = v1_q;
            prod_d = w_row_sum[2] + w_cpa_carry;
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            prod_q <= '0;
        end else begin
            v2_q   <= v2_d;
            prod_q <= prod_d;
        end
    end
`endif

endmodule : pp_compress_pipe
`default_nettype wire

// File: tb/tb_pp_compress_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_compress_pipe
//  Description : Self-checking bench for pp_compress_pipe. A queue-based
//                reference model holds the expected products (plain 32-bit
//                sums) in acceptance order, the in-flight count and the
//                accept cycle of each set. Honours PP_COMPRESS_CPA_STAGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_compress_pipe;

`ifdef PP_COMPRESS_CPA_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pp [8];
    logic [31:0] out_product;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    int          acc_q [$];
    bit          head_seen  = 1'b0;
    bit          strict_lat = 1'b1;
    int          cyc        = 0;
    int          n_acc      = 0;

    always #5 clk = ~clk;

    pp_compress_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .PP0         (pp[0]),
        .PP1         (pp[1]),
        .PP2         (pp[2]),
        .PP3         (pp[3]),
        .PP4         (pp[4]),
        .PP5         (pp[5]),
        .PP6         (pp[6]),
        .PP7         (pp[7]),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_sum();
        logic [31:0] s = '0;
        for (int k = 0; k < 8; k++) s = s + pp[k];
        return s;
    endfunction

    task automatic zero_pps();
        for (int k = 0; k < 8; k++) pp[k] = '0;
    endtask

    // One clock: inputs already driven after the falling edge; check mid-cycle,
    // update the model with this cycle's handshakes, then cross the rising edge.
    task automatic cycle();
        int lat;
        #2;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            head_seen = 1'b0;
        end else begin
            check_eq("in_ready", in_ready, (exp_q.size() < LAT || out_ready) ? 32'd1 : 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", out_valid, 32'd0);
                end else begin
                    check_eq("out_product", out_product, exp_q[0]);
                    if (!head_seen) begin
                        lat = cyc - acc_q[0];
                        if (strict_lat) check_eq("latency", lat, LAT);
                        else            check_eq("latency_min", (lat >= LAT) ? 32'd1 : 32'd0, 32'd1);
                        head_seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum());
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle();
        repeat (2) cycle();
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        zero_pps();
        @(negedge clk);
        in_valid = 1'b1;            // presented during reset: must not be accepted
        pp[0] = 32'h55;
        repeat (2) cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        zero_pps();
        #1;
        check_eq("reset_out_valid",   out_valid,   32'd0);
        check_eq("reset_out_product", out_product, 32'd0);
        check_eq("reset_in_ready",    in_ready,    32'd1);

        // Simple sum 3 + 5
        pp[0] = 32'd3; pp[1] = 32'd5; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; zero_pps();
        drain("drain_simple");

        // All ones: 8 * (2^32 - 1) wraps to 0xFFFFFFF8
        for (int k = 0; k < 8; k++) pp[k] = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; zero_pps();
        drain("drain_all_ones");

        // Four back-to-back sets at full throughput
        for (int i = 1; i <= 4; i++) begin
            pp[0] = i; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; zero_pps();
        drain("drain_b2b");

        // Stall: five sets offered with out_ready low, then release
        strict_lat = 1'b0;
        out_ready  = 1'b0;
        base       = n_acc;
        for (int i = 0; i < 8; i++) begin
            pp[0] = 32'd10 + (n_acc - base);
            in_valid = 1'b1;
            cycle();
        end
        check_eq("stall_accepts", n_acc - base, LAT);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_acc - base) < 5; i++) begin
            pp[0] = 32'd10 + (n_acc - base);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; zero_pps();
        check_eq("stall_total_accepts", n_acc - base, 32'd5);
        drain("drain_stall");

        // Reset with two sets in flight
        strict_lat = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pp[0] = 32'h100 + i; pp[3] = 32'h7; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; zero_pps();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid",   out_valid,   32'd0);
        check_eq("midrst_out_product", out_product, 32'd0);
        check_eq("midrst_in_ready",    in_ready,    32'd1);
        repeat (6) cycle();

        // Randomized traffic with random back-pressure and rare resets
        strict_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 8; k++)
                pp[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle();
        end
        rst = 1'b0;
        zero_pps();
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pp_compress_pipe
`default_nettype wire

// File: doc/pp_compress_pipe.md
PP_COMPRESS_PIPE -- requirements
Module: pp_compress_pipe

Interface
REQ-001 SHALL have parameter PP_NUM, default 8, number of partial products (fixed at 8 in this revision).
REQ-002 SHALL have parameter PP_WIDTH, default 32, partial-product and product width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, PP0..PP7 hold a valid set.
REQ-006 SHALL have port in_ready, output, 1, block accepts a set this cycle.
REQ-007 SHALL have ports PP0..PP7, input, 32 each, aligned partial products from the Booth partial-product stage.
REQ-008 SHALL have port out_valid, output, 1, out_product holds a result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-010 SHALL have port out_product, output, 32, reduced product.

Function
REQ-011 SHALL compute out_product = (PP0+PP1+...+PP7) mod 2^32; bits above 31 discarded at every stage, including carry shifts.
REQ-012 Stage 1 SHALL compress {PP0..PP3} and {PP4..PP7} with two 4:2 compressor rows into four 32-bit vectors (sum, carry<<1 each), then register them.
REQ-013 Stage 2 SHALL compress those four vectors with one 4:2 row into sum/carry vectors, then register them.
REQ-014 Stage 3 SHALL add sum+carry with a 32-bit carry-propagate adder and register the result into out_product.
REQ-015 A set SHALL transfer in when in_valid & in_ready; a result SHALL transfer out when out_valid & out_ready.
REQ-016 Each stage k SHALL hold a valid bit v_k; enables SHALL be en3 = ~v3 | out_ready, en2 = ~v2 | en3, en1 = ~v1 | en2; in_ready = en1 (combinational).
REQ-017 On en_k, stage k SHALL load data and valid from its upstream; on ~en_k, stage k SHALL hold data and valid unchanged.
REQ-018 out_valid SHALL equal v3; out_product SHALL stay stable while out_valid & ~out_ready.
REQ-019 Latency SHALL be 3 cycles from input handshake to out_valid; throughput one set per cycle when out_ready = 1.
REQ-020 Results SHALL leave in acceptance order; no set dropped or duplicated.
REQ-021 Bubbles SHALL collapse: an empty stage loads even when a later stage is stalled.
REQ-022 Simultaneous output handshake and a full pipeline SHALL allow a new input in the same cycle.

Reset
REQ-023 When rst = 1 at a clock edge, all v_k SHALL clear to 0 and all data registers SHALL clear to 0.
REQ-024 After reset: out_valid = 0, out_product = 0, in_ready = 1.
REQ-025 Reset mid-operation SHALL discard in-flight sets; no result from them SHALL ever appear.
REQ-026 An input presented while rst = 1 SHALL NOT be accepted.

Configuration
REQ-027 Macro PP_COMPRESS_CPA_STAGE_EN defined: three stages as in REQ-012..014, latency 3.
REQ-028 Macro PP_COMPRESS_CPA_STAGE_EN undefined: the CPA SHALL sit combinationally after the stage-2 compressor, with its sum registered as out_product. There SHALL be two stages (en2 = ~v2 | out_ready) and latency 2; all other rules are unchanged.

Structure
REQ-029 Shared package mult_pkg SHALL hold PP_NUM, PP_WIDTH and the pipeline-depth constants for both configurations.
REQ-030 Sub-module compressor42 SHALL implement a 1-bit 4:2 compressor (inputs a,b,c,d,cin; outputs sum, carry, cout). Rows SHALL be built by instancing it per bit, with cout chained to the next bit's cin and bit 0 cin = 0.

Verification
REQ-031 PP0=3, PP1=5, others 0, out_ready=1 -> out_valid 3 cycles later for one cycle, out_product=0x00000008.
REQ-032 All PPk=0xFFFFFFFF -> out_product=0xFFFFFFF8 (mod-2^32 wrap).
REQ-033 Four back-to-back sets, with PP0 = 1,2,3,4 and other PPs 0, and out_ready=1 -> in_ready stays 1; outputs 1,2,3,4 on four consecutive cycles.
REQ-034 out_ready=0 while five sets are offered -> in_ready drops after 3 accepts and out_product holds the first result. Raising out_ready -> remaining results drain in order.
REQ-035 rst pulsed with 2 sets in flight -> out_valid=0, out_product=0, in_ready=1 next cycle; no stale result emitted afterward.
REQ-036 Build without PP_COMPRESS_CPA_STAGE_EN, rerun REQ-031 -> result appears 2 cycles after the handshake.
